// File: rtl/spi_master_arbiter_if.sv
// Bundle between the requesters, the arbiter and one shared spi_master.
// The arbiter uses the slave view; the requester/spi_master side uses the master view.
interface spi_master_arbiter_if #(
   parameter int NUM_REQ                 = 4,
   parameter int SPI_DATA_WIDTH          = 8,
   parameter int SPI_CLOCK_DIVIDER_WIDTH = 5
);
   logic [NUM_REQ-1:0]                         i_req;
   logic [NUM_REQ-1:0]                         i_req_lock;
   logic [NUM_REQ*SPI_DATA_WIDTH-1:0]          i_req_data;
   logic [NUM_REQ-1:0]                         i_req_cpol;
   logic [NUM_REQ-1:0]                         i_req_cpha;
   logic [NUM_REQ*SPI_CLOCK_DIVIDER_WIDTH-1:0] i_req_div;
   logic [NUM_REQ-1:0]                         o_req_ack;
   logic [NUM_REQ-1:0]                         o_req_done;
   logic [SPI_DATA_WIDTH-1:0]                  o_rsp_data;
   logic                                       o_rsp_error;
   logic [NUM_REQ-1:0]                         o_grant;
   logic                                       o_spi_enable;
   logic                                       o_spi_cpol;
   logic                                       o_spi_cpha;
   logic [SPI_CLOCK_DIVIDER_WIDTH-1:0]         o_spi_div;
   logic [SPI_DATA_WIDTH-1:0]                  o_spi_data;
   logic [SPI_DATA_WIDTH-1:0]                  i_spi_data;
   logic                                       i_spi_done;
   logic                                       i_spi_busy;

   modport slave (
      input  i_req, i_req_lock, i_req_data, i_req_cpol, i_req_cpha, i_req_div,
      input  i_spi_data, i_spi_done, i_spi_busy,
      output o_req_ack, o_req_done, o_rsp_data, o_rsp_error, o_grant,
      output o_spi_enable, o_spi_cpol, o_spi_cpha, o_spi_div, o_spi_data
   );

   modport master (
      output i_req, i_req_lock, i_req_data, i_req_cpol, i_req_cpha, i_req_div,
      output i_spi_data, i_spi_done, i_spi_busy,
      input  o_req_ack, o_req_done, o_rsp_data, o_rsp_error, o_grant,
      input  o_spi_enable, o_spi_cpol, o_spi_cpha, o_spi_div, o_spi_data
   );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ requesters,
// with locked bursts and a watchdog on the spi_master done pulse.
module spi_master_arbiter #(
   parameter int NUM_REQ                 = 4,
   parameter int SPI_DATA_WIDTH          = 8,
   parameter int SPI_CLOCK_DIVIDER_WIDTH = 5,
   parameter int TIMEOUT_WIDTH           = 16
) (
   input logic                 i_clock,
   input logic                 i_reset,
   spi_master_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // Last WAIT count before the terminal value: the word times out on its 2**W-1'th WAIT cycle.
   localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

   state_t                             state_q, state_d;
   logic [IDX_W-1:0]                   owner_q, owner_d, last_q, last_d;
   logic [IDX_W-1:0]                   win_idx, cand;
   logic                               win_found;
   logic [TIMEOUT_WIDTH-1:0]           wd_q, wd_d;
   logic [NUM_REQ-1:0]                 grant_q, grant_d, ack_q, ack_d, done_q, done_d;
   logic [SPI_DATA_WIDTH-1:0]          rsp_data_q, rsp_data_d, data_q, data_d;
   logic                               rsp_error_q, rsp_error_d, enable_q, enable_d;
   logic                               cpol_q, cpol_d, cpha_q, cpha_d;
   logic [SPI_CLOCK_DIVIDER_WIDTH-1:0] div_q, div_d;

   logic [SPI_DATA_WIDTH-1:0]          req_data [NUM_REQ];
   logic [SPI_CLOCK_DIVIDER_WIDTH-1:0] req_div  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_data[g] = bus.i_req_data[g*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
      assign req_div[g]  = bus.i_req_div[g*SPI_CLOCK_DIVIDER_WIDTH +: SPI_CLOCK_DIVIDER_WIDTH];
   end

   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
      int s;
      s = (int'(base) + off) % NUM_REQ;
      return s[IDX_W-1:0];
   endfunction

   // Search starts one past the last served requester so nobody is starved.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = rr_idx(last_q, k);
         if (!win_found && bus.i_req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      wd_d        = wd_q;
      grant_d     = grant_q;
      ack_d       = '0;
      done_d      = '0;
      rsp_error_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      enable_d    = 1'b0;
      cpol_d      = cpol_q;
      cpha_d      = cpha_q;
      div_d       = div_q;
      data_d      = data_q;
      unique case (state_q)
         S_IDLE: begin
            if (win_found && !bus.i_spi_busy) begin
               owner_d = win_idx;
               grant_d = NUM_REQ'(1) << win_idx;
               cpol_d  = bus.i_req_cpol[win_idx];
               cpha_d  = bus.i_req_cpha[win_idx];
               div_d   = req_div[win_idx];
               data_d  = req_data[win_idx];
               state_d = S_START;
            end
         end
         S_START: begin
            enable_d = 1'b1;
            ack_d    = grant_q;
            wd_d     = '0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_q + 1'b1;
            if (bus.i_spi_done) begin
               rsp_data_d = bus.i_spi_data;
               done_d     = grant_q;
               // A locked, still-requesting owner keeps the bus; only its data is reloaded.
               if (bus.i_req_lock[owner_q] && bus.i_req[owner_q]) begin
                  data_d  = req_data[owner_q];
                  state_d = S_START;
               end else begin
                  grant_d = '0;
                  last_d  = owner_q;
                  state_d = S_IDLE;
               end
            end else if (wd_q == WD_LAST) begin
               done_d      = grant_q;
               rsp_error_d = 1'b1;
               grant_d     = '0;
               last_d      = owner_q;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      if (i_reset) begin
         state_q     <= S_IDLE;
         owner_q     <= '0;
         last_q      <= IDX_W'(NUM_REQ - 1);
         wd_q        <= '0;
         grant_q     <= '0;
         ack_q       <= '0;
         done_q      <= '0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
         enable_q    <= 1'b0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         div_q       <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         wd_q        <= wd_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         done_q      <= done_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
         enable_q    <= enable_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         div_q       <= div_d;
         data_q      <= data_d;
      end
   end

   assign bus.o_grant      = grant_q;
   assign bus.o_req_ack    = ack_q;
   assign bus.o_req_done   = done_q;
   assign bus.o_rsp_data   = rsp_data_q;
   assign bus.o_rsp_error  = rsp_error_q;
   assign bus.o_spi_enable = enable_q;
   assign bus.o_spi_cpol   = cpol_q;
   assign bus.o_spi_cpha   = cpha_q;
   assign bus.o_spi_div    = div_q;
   assign bus.o_spi_data   = data_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: a transaction-level predictor checked every
// cycle, a loopback spi_master stand-in, and literal checks of the key scenarios.
module tb_spi_master_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int CW = 5;
   localparam int TW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_master_arbiter_if #(.NUM_REQ(N), .SPI_DATA_WIDTH(DW), .SPI_CLOCK_DIVIDER_WIDTH(CW)) bus();

   spi_master_arbiter #(
      .NUM_REQ(N), .SPI_DATA_WIDTH(DW), .SPI_CLOCK_DIVIDER_WIDTH(CW), .TIMEOUT_WIDTH(TW)
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .bus    (bus)
   );

   logic [DW-1:0] rq_data [N];
   logic [CW-1:0] rq_div  [N];
   for (genvar g = 0; g < N; g++) begin : g_pack
      assign bus.i_req_data[g*DW +: DW] = rq_data[g];
      assign bus.i_req_div[g*CW +: CW]  = rq_div[g];
   end

   int n_vec = 0;
   int n_mis = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- spi_master stand-in: loopback after lat cycles ----------------
   bit            hang     = 1'b0;
   bit            stray_en = 1'b0;
   int            lat      = 4;
   int            spi_cnt  = 0;
   logic [DW-1:0] spi_cap  = '0;

   always @(negedge clk) begin
      bus.i_spi_done = 1'b0;
      if (rst) begin
         bus.i_spi_busy = 1'b0;
         bus.i_spi_data = '0;
         spi_cnt        = 0;
      end else if (bus.i_spi_busy) begin
         spi_cnt--;
         if (spi_cnt == 0) begin
            bus.i_spi_done = 1'b1;
            bus.i_spi_data = spi_cap;
            bus.i_spi_busy = 1'b0;
         end
      end else if (bus.o_spi_enable && !hang) begin
         bus.i_spi_busy = 1'b1;
         spi_cnt        = lat;
         spi_cap        = bus.o_spi_data;
      end else if (stray_en) begin
         bus.i_spi_done = 1'b1;
         bus.i_spi_data = 8'hEE;
      end
   end

   // ---------------- transaction-level predictor ----------------
   int            m_owner  = -1;
   int            m_last   = N - 1;
   int            m_waited = 0;
   bit            m_start  = 1'b0;
   logic [N-1:0]  e_grant, e_ack, e_done;
   logic [DW-1:0] e_rsp, e_data;
   logic          e_err, e_en, e_cpol, e_cpha;
   logic [CW-1:0] e_div;

   task automatic release_bus();
      m_last  = m_owner;
      m_owner = -1;
      e_grant = '0;
   endtask

   task automatic model_step();
      e_ack  = '0;
      e_done = '0;
      e_err  = 1'b0;
      e_en   = 1'b0;
      if (rst) begin
         m_owner = -1; m_last = N - 1; m_start = 1'b0; m_waited = 0;
         e_grant = '0; e_rsp = '0; e_data = '0; e_cpol = 1'b0; e_cpha = 1'b0; e_div = '0;
      end else if (m_owner < 0) begin
         if (bus.i_req != '0 && !bus.i_spi_busy) begin
            for (int k = 1; k <= N; k++)
               if (m_owner < 0 && bus.i_req[(m_last + k) % N]) m_owner = (m_last + k) % N;
            e_grant = N'(1) << m_owner;
            e_data  = rq_data[m_owner];
            e_div   = rq_div[m_owner];
            e_cpol  = bus.i_req_cpol[m_owner];
            e_cpha  = bus.i_req_cpha[m_owner];
            m_start = 1'b1;
         end
      end else if (m_start) begin
         e_en     = 1'b1;
         e_ack    = e_grant;
         m_start  = 1'b0;
         m_waited = 0;
      end else begin
         m_waited++;
         if (bus.i_spi_done) begin
            e_rsp  = bus.i_spi_data;
            e_done = e_grant;
            if (bus.i_req_lock[m_owner] && bus.i_req[m_owner]) begin
               e_data  = rq_data[m_owner];
               m_start = 1'b1;
            end else begin
               release_bus();
            end
         end else if (m_waited == 2**TW - 1) begin
            e_done = e_grant;
            e_err  = 1'b1;
            release_bus();
         end
      end
   endtask

   function automatic logic [63:0] dut_vec();
      return 64'({bus.o_grant, bus.o_req_ack, bus.o_req_done, bus.o_rsp_data, bus.o_rsp_error,
                  bus.o_spi_enable, bus.o_spi_cpol, bus.o_spi_cpha, bus.o_spi_div, bus.o_spi_data});
   endfunction

   function automatic logic [63:0] exp_vec();
      return 64'({e_grant, e_ack, e_done, e_rsp, e_err, e_en, e_cpol, e_cpha, e_div, e_data});
   endfunction

   // Event logs used by the literal scenario checks.
   int            cyc     = 0;
   int            en_cyc  = 0;
   int            done_cyc = 0;
   int            grant_log [$];
   logic [N-1:0]  done_log  [$];
   logic [DW-1:0] rsp_log   [$];

   always @(posedge clk) begin
      model_step();
      #1;
      check($sformatf("outputs@%0t", $time), dut_vec(), exp_vec());
      cyc++;
      if (bus.o_spi_enable) en_cyc = cyc;
      for (int k = 0; k < N; k++) if (bus.o_req_ack[k]) grant_log.push_back(k);
      if (bus.o_req_done != '0) begin
         done_log.push_back(bus.o_req_done);
         rsp_log.push_back(bus.o_rsp_data);
         done_cyc = cyc;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.i_req      = '0;
      bus.i_req_lock = '0;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic wait_ack(input int k, input string name);
      int i = 0;
      while (!bus.o_req_ack[k] && i < 60) begin
         @(negedge clk);
         i++;
      end
      check({name, "_ack"}, 64'(bus.o_req_ack[k]), 64'(1));
   endtask

   task automatic wait_done(input string name);
      int i = 0;
      while (bus.o_req_done == '0 && i < 60) begin
         @(negedge clk);
         i++;
      end
      check({name, "_done_seen"}, 64'(bus.o_req_done != '0), 64'(1));
   endtask

   int gb, rb;
   int rr_exp [5] = '{0, 1, 2, 3, 0};
   int bu_exp [4] = '{2, 2, 2, 0};
   logic [DW-1:0] bu_rsp [4] = '{8'hA1, 8'hA2, 8'hA3, 8'h0F};

   initial begin
      bus.i_req = '0; bus.i_req_lock = '0; bus.i_req_cpol = '0; bus.i_req_cpha = '0;
      for (int k = 0; k < N; k++) begin
         rq_data[k] = '0;
         rq_div[k]  = '0;
      end
      tick(3);
      rst = 1'b0;
      check("reset_outputs", dut_vec(), 64'(0));

      // Single request from requester 0, loopback answer.
      rq_data[0] = 8'h5D; rq_div[0] = 5'd4; bus.i_req = 4'b0001;
      tick(1);
      check("first_grant", 64'(bus.o_grant), 64'(4'b0001));
      check("no_enable_yet", 64'(bus.o_spi_enable), 64'(0));
      tick(1);
      check("enable_2cyc", 64'({bus.o_spi_enable, bus.o_req_ack, bus.o_spi_data, bus.o_spi_div}),
            64'({1'b1, 4'b0001, 8'h5D, 5'd4}));
      bus.i_req = '0;
      wait_done("single");
      check("single_done", 64'({bus.o_req_done, bus.o_rsp_data, bus.o_rsp_error}),
            64'({4'b0001, 8'h5D, 1'b0}));
      tick(2);
      check("single_idle", 64'(bus.o_grant), 64'(0));

      // All four requesting, no lock: strict rotation from reset.
      do_reset();
      gb = grant_log.size();
      bus.i_req = 4'b1111;
      for (int i = 0; i < 200 && grant_log.size() < gb + 5; i++) tick(1);
      bus.i_req = '0;
      for (int i = 0; i < 5; i++)
         check($sformatf("rr_order_%0d", i),
               64'((grant_log.size() > gb + i) ? grant_log[gb + i] : -1), 64'(rr_exp[i]));
      tick(20);

      // Locked burst of three words from requester 2 while requester 0 waits.
      do_reset();
      gb = grant_log.size(); rb = rsp_log.size();
      rq_data[2] = 8'hA1; bus.i_req_lock[2] = 1'b1; bus.i_req[2] = 1'b1;
      wait_ack(2, "burst_w1");
      rq_data[0] = 8'h0F; bus.i_req[0] = 1'b1; rq_data[2] = 8'hA2;
      tick(1);
      wait_ack(2, "burst_w2");
      rq_data[2] = 8'hA3;
      tick(1);
      wait_ack(2, "burst_w3");
      bus.i_req_lock[2] = 1'b0; bus.i_req[2] = 1'b0;
      tick(1);
      wait_ack(0, "burst_r0");
      bus.i_req[0] = 1'b0;
      tick(1);
      wait_done("burst_r0");
      tick(2);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("burst_grant_%0d", i),
               64'((grant_log.size() > gb + i) ? grant_log[gb + i] : -1), 64'(bu_exp[i]));
         check($sformatf("burst_rsp_%0d", i),
               64'((rsp_log.size() > rb + i) ? rsp_log[rb + i] : 8'hXX), 64'(bu_rsp[i]));
      end

      // Config held while granted; request dropped right after grant still completes.
      do_reset();
      rq_data[1] = 8'h3C; bus.i_req_cpol[1] = 1'b1; bus.i_req_cpha[1] = 1'b1; rq_div[1] = 5'd7;
      bus.i_req = 4'b0010;
      tick(1);
      bus.i_req = '0;
      wait_ack(1, "cfg");
      bus.i_req_cpol[1] = 1'b0; bus.i_req_cpha[1] = 1'b0; rq_div[1] = 5'd2; rq_data[1] = 8'hFF;
      wait_done("cfg");
      check("cfg_hold", 64'({bus.o_req_done, bus.o_spi_cpol, bus.o_spi_cpha, bus.o_spi_div, bus.o_rsp_data}),
            64'({4'b0010, 1'b1, 1'b1, 5'd7, 8'h3C}));
      tick(2);

      // Stray done pulses while idle are ignored.
      rb = done_log.size();
      stray_en = 1'b1;
      tick(4);
      stray_en = 1'b0;
      tick(2);
      check("stray_ignored", 64'({done_log.size() - rb, bus.o_rsp_data}), 64'({32'd0, 8'h3C}));

      // spi_master never answers: watchdog ends the word with an error.
      hang = 1'b1;
      rq_data[3] = 8'h77; bus.i_req = 4'b1000;
      wait_ack(3, "timeout");
      bus.i_req = '0;
      wait_done("timeout");
      check("timeout_done", 64'({bus.o_req_done, bus.o_rsp_error, bus.o_rsp_data}),
            64'({4'b1000, 1'b1, 8'h3C}));
      check("timeout_cycles", 64'(done_cyc - en_cyc), 64'(15));
      tick(1);
      check("timeout_idle", 64'(bus.o_grant), 64'(0));
      hang = 1'b0;
      tick(2);

      // Reset in the middle of WAIT abandons the word silently.
      lat = 8;
      rq_data[0] = 8'h42; bus.i_req = 4'b0001;
      wait_ack(0, "midrst");
      tick(2);
      rst = 1'b1;
      tick(1);
      check("midrst_outputs", dut_vec(), 64'(0));
      rst = 1'b0; bus.i_req = '0;
      rb = done_log.size();
      tick(15);
      check("midrst_no_done", 64'(done_log.size() - rb), 64'(0));

      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end
endmodule
